// File: rtl/shift_iter_unit.sv
// Iterative 32-bit shifter (SLL / SRA): one power-of-two stage (16, 8, 4, 2, 1) per clock,
// fixed five-cycle latency from the capture edge, start/ready handshake with a busy stall.
module shift_iter_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic               ctrl_dir,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   stage_val;
  logic [SHAMT_W-1:0] shamt_q;
  logic               dir_q;
  logic [2:0]         k;

  // One stage of the shift: k selects the 2^k distance, shamt_q[k] decides whether it applies.
  always_comb begin
    stage_val = acc;
    case (k)
      3'd4: if (shamt_q[4])
              stage_val = dir_q ? {{16{acc[WIDTH-1]}}, acc[WIDTH-1:16]} : {acc[WIDTH-17:0], 16'b0};
      3'd3: if (shamt_q[3])
              stage_val = dir_q ? {{8{acc[WIDTH-1]}}, acc[WIDTH-1:8]} : {acc[WIDTH-9:0], 8'b0};
      3'd2: if (shamt_q[2])
              stage_val = dir_q ? {{4{acc[WIDTH-1]}}, acc[WIDTH-1:4]} : {acc[WIDTH-5:0], 4'b0};
      3'd1: if (shamt_q[1])
              stage_val = dir_q ? {{2{acc[WIDTH-1]}}, acc[WIDTH-1:2]} : {acc[WIDTH-3:0], 2'b0};
      3'd0: if (shamt_q[0])
              stage_val = dir_q ? {acc[WIDTH-1], acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};
      default: stage_val = acc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_start) state_next = SHIFT;
      SHIFT:   if (k == 3'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign data_ready = (state == DONE);

  // data_out is loaded only on the final stage so intermediate acc values never leak out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      shamt_q  <= '0;
      dir_q    <= 1'b0;
      k        <= 3'd0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            acc     <= data_in;
            shamt_q <= shamt;
            dir_q   <= ctrl_dir;
            k       <= 3'd4;
          end
        end
        SHIFT: begin
          acc <= stage_val;
          if (k == 3'd0) data_out <= stage_val;
          else           k <= k - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_iter_unit.sv
// Self-checking bench for shift_iter_unit: directed corner cases followed by a random sweep
// compared against an arithmetic reference model.
module tb_shift_iter_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_dir;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        data_ready;
  logic        busy;

  int checks;
  int failures;
  int readyCount;

  shift_iter_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_start (ctrl_start),
    .ctrl_dir   (ctrl_dir),
    .data_in    (data_in),
    .shamt      (shamt),
    .data_out   (data_out),
    .data_ready (data_ready),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (data_ready) readyCount++;

  function automatic logic [31:0] refShift(input logic dir, input logic [31:0] d, input int s);
    logic signed [31:0] sd;
    sd = d;
    if (dir) return sd >>> s;
    return d << s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dir, input logic [31:0] d, input logic [4:0] s,
                               input bit repulse);
    int idx;
    logic [31:0] exp;
    exp = refShift(dir, d, int'(s));
    @(negedge clock);
    ctrl_start = 1'b1;
    ctrl_dir   = dir;
    data_in    = d;
    shamt      = s;
    @(negedge clock);
    idx = 0;
    while (!data_ready && idx < 20) begin
      checkOutput("busy_in_shift", {31'b0, busy}, 32'd1);
      ctrl_start = repulse && (idx == 1);
      ctrl_dir   = 1'($urandom);
      data_in    = repulse ? 32'hFFFF_FFFF : $urandom;
      shamt      = repulse ? 5'd1 : 5'($urandom);
      @(negedge clock);
      idx++;
    end
    checkOutput("latency", idx, 32'd5);
    checkOutput("result", data_out, exp);
    checkOutput("busy_in_done", {31'b0, busy}, 32'd1);
    ctrl_start = repulse;
    data_in    = 32'hFFFF_FFFF;
    shamt      = 5'd1;
    @(negedge clock);
    ctrl_start = 1'b0;
    checkOutput("ready_pulse_end", {31'b0, data_ready}, 32'd0);
    checkOutput("busy_after_done", {31'b0, busy}, 32'd0);
    checkOutput("result_held", data_out, exp);
  endtask

  initial begin
    int pulsesBefore;
    checks     = 0;
    failures   = 0;
    readyCount = 0;
    reset      = 1'b1;
    ctrl_start = 1'b0;
    ctrl_dir   = 1'b0;
    data_in    = '0;
    shamt      = '0;

    #12;
    checkOutput("reset_data_out", data_out, 32'd0);
    checkOutput("reset_ready", {31'b0, data_ready}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases
    applyStimulus(1'b0, 32'h0000_0001, 5'd31, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 5'd4, 1'b0);
    applyStimulus(1'b1, 32'h7FFF_FFF0, 5'd2, 1'b0);
    applyStimulus(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0001, 5'd31, 1'b0);

    // Re-pulsed start while busy is ignored; exactly one ready pulse for the op
    pulsesBefore = readyCount;
    applyStimulus(1'b0, 32'h0000_000F, 5'd4, 1'b1);
    checkOutput("single_pulse", readyCount - pulsesBefore, 32'd1);
    applyStimulus(1'b0, 32'h0000_0003, 5'd30, 1'b0);

    // Reset in the middle of an operation
    @(negedge clock);
    ctrl_start = 1'b1;
    ctrl_dir   = 1'b1;
    data_in    = 32'h8000_0000;
    shamt      = 5'd8;
    @(negedge clock);
    ctrl_start = 1'b0;
    repeat (2) @(negedge clock);
    pulsesBefore = readyCount;
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset_ready", {31'b0, data_ready}, 32'd0);
    checkOutput("midreset_data_out", data_out, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("midreset_no_pulse", readyCount - pulsesBefore, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_0000, 5'd16, 1'b0);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom), $urandom, 5'($urandom_range(0, 31)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
